// File: rtl/day6_col_feeder_if.sv
// Handshake bundles for the Day 6 column feeder.
//   day6_byte_if : raw ASCII byte stream into the feeder.
//     in_data/in_valid/in_last driven by the master, in_ready by the slave.
//   day6_col_if  : per-column records out of the feeder.
//     record fields, col_valid and frame_start driven by the master,
//     out_ready driven by the slave (the column solver).

interface day6_byte_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

interface day6_col_if;
  logic [3:0] r0_digit;
  logic [3:0] r1_digit;
  logic [3:0] r2_digit;
  logic [3:0] r3_digit;
  logic       r0_space;
  logic       r1_space;
  logic       r2_space;
  logic       r3_space;
  logic       block_start;
  logic       block_plus;
  logic       col_last;
  logic       frame_last;
  logic       col_valid;
  logic       out_ready;
  logic       frame_start;

  modport master (
    output r0_digit, r1_digit, r2_digit, r3_digit,
    output r0_space, r1_space, r2_space, r3_space,
    output block_start, block_plus, col_last, frame_last, col_valid, frame_start,
    input  out_ready
  );
  modport slave (
    input  r0_digit, r1_digit, r2_digit, r3_digit,
    input  r0_space, r1_space, r2_space, r3_space,
    input  block_start, block_plus, col_last, frame_last, col_valid, frame_start,
    output out_ready
  );
endinterface

// File: rtl/day6_col_feeder.sv
// day6_col_feeder: buffers the Day 6 worksheet text (4 digit rows + 1 op
// row, row-major) and replays it column-major as column records, dropping
// separator columns.
//
// Ports:
//   clock     sole clock, rising edge
//   clear     asynchronous active-high reset
//   in_if     byte stream in (slave)
//   out_if    column records out + frame_start pulse (master)
//   bad_char  sticky: illegal character seen this frame
//   overflow  sticky: a row exceeded MAX_COLS
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// LOAD  | storing bytes into the line buffers
// SCAN  | walking columns, loading the output register
// DONE  | last record loaded, waiting for it to be accepted

module day6_col_feeder #(
  parameter int MAX_COLS = 4096,
  parameter int CW       = $clog2(MAX_COLS) + 1
) (
  input  logic        clock,
  input  logic        clear,
  day6_byte_if.slave  in_if,
  day6_col_if.master  out_if,
  output logic        bad_char,
  output logic        overflow
);

  localparam int AW = $clog2(MAX_COLS);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COLS);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [1:0] OP_BLANK = 2'd0;
  localparam logic [1:0] OP_PLUS  = 2'd1;
  localparam logic [1:0] OP_MUL   = 2'd2;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
  state_t state, state_nx;

  // Line buffers: {space, digit} for rows 0-3, op code for row 4.
  // Never cleared; per-row lengths mask stale contents.
  logic [4:0] dbuf [4][MAX_COLS];
  logic [1:0] obuf [MAX_COLS];

  logic [CW-1:0] len [5];
  logic [2:0]    row;
  logic [CW-1:0] col, last_occ, ptr;
  logic          occ_seen, after_sep;

  logic       col_valid;
  logic [3:0] rec_dig [4];
  logic [3:0] rec_spc;
  logic       rec_bs, rec_bp, rec_cl, rec_fl, frame_start_q;

  // load-side decode
  logic          in_rdy, accept, start, is_nl, char_bad, non_space, fits;
  logic          wr_en, drop, end_row, close, occ_upd, seen_base, seen_nx;
  logic [2:0]    row_base;
  logic [CW-1:0] col_base, occ_base, occ_nx, end_len;
  logic [3:0]    wr_digit;
  logic          wr_space;
  logic [1:0]    wr_op;

  // scan-side decode
  logic          advance, bs, at_last, cur_sep, nxt_sep;
  logic [CW-1:0] ptr1;
  logic [AW-1:0] ptr_a, ptr1_a;
  logic [3:0]    cur_dig [4];
  logic [3:0]    cur_spc, nxt_spc;
  logic [1:0]    cur_op, nxt_op;

  assign in_rdy          = (state == IDLE) || (state == LOAD);
  assign in_if.in_ready  = in_rdy;

  // Column read at ptr, plus separator lookahead at ptr+1 for col_last.
  always_comb begin
    ptr1    = ptr + ONE;
    ptr_a   = ptr[AW-1:0];
    ptr1_a  = ptr1[AW-1:0];
    cur_spc = 4'hF;
    nxt_spc = 4'hF;
    for (int r = 0; r < 4; r++) begin
      cur_dig[r] = 4'd0;
      if (ptr < len[r]) begin
        cur_spc[r] = dbuf[r][ptr_a][4];
        cur_dig[r] = dbuf[r][ptr_a][3:0];
      end
      if (ptr1 < len[r]) nxt_spc[r] = dbuf[r][ptr1_a][4];
    end
    cur_op  = (ptr < len[4]) ? obuf[ptr_a] : OP_BLANK;
    nxt_op  = (ptr1 < len[4]) ? obuf[ptr1_a] : OP_BLANK;
    cur_sep = (&cur_spc) && (cur_op == OP_BLANK);
    nxt_sep = (&nxt_spc) && (nxt_op == OP_BLANK);
    bs      = (ptr == '0) || after_sep;
    at_last = (ptr == last_occ);
  end

  // Next-state and load decode. The first byte in IDLE sees per-frame
  // state as already cleared, so it is handled exactly like a LOAD byte.
  always_comb begin
    state_nx  = state;
    accept    = in_if.in_valid & in_rdy;
    start     = accept & (state == IDLE);
    row_base  = start ? 3'd0 : row;
    col_base  = start ? '0 : col;
    occ_base  = start ? '0 : last_occ;
    seen_base = start ? 1'b0 : occ_seen;
    is_nl     = (in_if.in_data == 8'h0A);

    wr_digit = 4'd0;
    wr_space = 1'b1;
    wr_op    = OP_BLANK;
    char_bad = 1'b0;
    if (row_base == 3'd4) begin
      case (in_if.in_data)
        8'h2B:   wr_op = OP_PLUS;
        8'h2A:   wr_op = OP_MUL;
        8'h20:   wr_op = OP_BLANK;
        default: char_bad = 1'b1;
      endcase
    end else if (in_if.in_data >= 8'h30 && in_if.in_data <= 8'h39) begin
      wr_space = 1'b0;
      wr_digit = in_if.in_data[3:0];
    end else if (in_if.in_data != 8'h20) begin
      char_bad = 1'b1;
    end

    non_space = (row_base == 3'd4) ? (wr_op != OP_BLANK) : ~wr_space;
    fits      = (col_base < MAX_C);
    wr_en     = accept & ~is_nl & fits;
    drop      = accept & ~is_nl & ~fits;
    end_row   = accept & (is_nl | in_if.in_last);
    close     = accept & ((is_nl & (row_base == 3'd4)) | in_if.in_last);
    end_len   = wr_en ? col_base + ONE : col_base;
    occ_upd   = wr_en & non_space;
    occ_nx    = (occ_upd && (col_base > occ_base)) ? col_base : occ_base;
    seen_nx   = seen_base | occ_upd;
    advance   = ~col_valid | out_if.out_ready;

    case (state)
      IDLE, LOAD: if (accept) state_nx = close ? (seen_nx ? SCAN : IDLE) : LOAD;
      SCAN:       if (advance && !cur_sep && at_last) state_nx = DONE;
      DONE:       if (col_valid && out_if.out_ready) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (row_base == 3'd4) obuf[col_base[AW-1:0]] <= wr_op;
      else                  dbuf[row_base[1:0]][col_base[AW-1:0]] <= {wr_space, wr_digit};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      row           <= '0;
      col           <= '0;
      last_occ      <= '0;
      occ_seen      <= 1'b0;
      ptr           <= '0;
      after_sep     <= 1'b0;
      for (int r = 0; r < 5; r++) len[r] <= '0;
      frame_start_q <= 1'b0;
      bad_char      <= 1'b0;
      overflow      <= 1'b0;
      col_valid     <= 1'b0;
      for (int r = 0; r < 4; r++) rec_dig[r] <= '0;
      rec_spc       <= '0;
      rec_bs        <= 1'b0;
      rec_bp        <= 1'b0;
      rec_cl        <= 1'b0;
      rec_fl        <= 1'b0;
    end else begin
      frame_start_q <= start;
      if (accept) begin
        row      <= end_row ? 3'(row_base + 3'd1) : row_base;
        col      <= end_row ? '0 : (wr_en ? col_base + ONE : col_base);
        last_occ <= occ_nx;
        occ_seen <= seen_nx;
        bad_char <= (start ? 1'b0 : bad_char) | (wr_en & char_bad);
        overflow <= (start ? 1'b0 : overflow) | drop;
        if (start) for (int r = 0; r < 5; r++) len[r] <= '0;
        if (end_row && row_base <= 3'd4) len[row_base] <= end_len;
        if (close) begin
          ptr       <= '0;
          after_sep <= 1'b0;
        end
      end
      if (state == SCAN && advance) begin
        ptr <= ptr1;
        if (cur_sep) begin
          after_sep <= 1'b1;
          col_valid <= 1'b0;
        end else begin
          after_sep <= 1'b0;
          col_valid <= 1'b1;
          for (int r = 0; r < 4; r++) rec_dig[r] <= cur_dig[r];
          rec_spc   <= cur_spc;
          rec_bs    <= bs;
          // A block start without a valid operator falls back to multiply.
          rec_bp    <= bs && (cur_op == OP_PLUS);
          rec_cl    <= at_last || nxt_sep;
          rec_fl    <= at_last;
          if (bs && cur_op == OP_BLANK) bad_char <= 1'b1;
        end
      end else if (state == DONE && col_valid && out_if.out_ready) begin
        col_valid <= 1'b0;
      end
    end
  end

  assign out_if.r0_digit    = rec_dig[0];
  assign out_if.r1_digit    = rec_dig[1];
  assign out_if.r2_digit    = rec_dig[2];
  assign out_if.r3_digit    = rec_dig[3];
  assign out_if.r0_space    = rec_spc[0];
  assign out_if.r1_space    = rec_spc[1];
  assign out_if.r2_space    = rec_spc[2];
  assign out_if.r3_space    = rec_spc[3];
  assign out_if.block_start = rec_bs;
  assign out_if.block_plus  = rec_bp;
  assign out_if.col_last    = rec_cl;
  assign out_if.frame_last  = rec_fl;
  assign out_if.col_valid   = col_valid;
  assign out_if.frame_start = frame_start_q;

endmodule

// File: tb/tb_day6_col_feeder.sv
module tb_day6_col_feeder;
  logic clock = 1'b0;
  logic clear;
  logic bad_char, overflow;
  always #5 clock = ~clock;

  day6_byte_if bif ();
  day6_col_if  cif ();

  day6_col_feeder dut (
    .clock    (clock),
    .clear    (clear),
    .in_if    (bif),
    .out_if   (cif),
    .bad_char (bad_char),
    .overflow (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // record layout: {d0,d1,d2,d3, s0,s1,s2,s3, block_start,block_plus,col_last,frame_last}
  function automatic logic [23:0] mk(input logic [3:0] d0, input logic [3:0] d1,
                                     input logic [3:0] d2, input logic [3:0] d3,
                                     input logic [3:0] s, input logic [3:0] f);
    return {d0, d1, d2, d3, s, f};
  endfunction

  function automatic logic [23:0] obs_rec();
    return {cif.r0_digit, cif.r1_digit, cif.r2_digit, cif.r3_digit,
            cif.r0_space, cif.r1_space, cif.r2_space, cif.r3_space,
            cif.block_start, cif.block_plus, cif.col_last, cif.frame_last};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bif.in_data  = b;
    bif.in_valid = 1'b1;
    bif.in_last  = last;
    @(negedge clock);
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
  endtask

  task automatic send_row(input string s, input logic last_on_nl);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    send_byte(8'h0A, last_on_nl);
  endtask

  task automatic send_basic();
    send_row("12 3", 1'b0);
    send_row("4  5", 1'b0);
    send_row(" 6 7", 1'b0);
    send_row("   8", 1'b0);
    send_row("*  +", 1'b0);
  endtask

  // Waits (bounded) for a record, checks it, and lets it be accepted.
  task automatic expect_rec(input string tag, input logic [23:0] exp);
    int k;
    k = 0;
    while (!cif.col_valid && k < 20) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_valid"}, {31'd0, cif.col_valid}, 32'd1);
    check(tag, {8'd0, obs_rec()}, {8'd0, exp});
    @(negedge clock);
  endtask

  logic [23:0] rec1, rec2, rec3, cur, prev;
  logic [23:0] cap [3];
  logic [3:0]  pat;
  logic        prev_stall;
  int          ncap, cyc;

  initial begin
    rec1 = mk(4'd1, 4'd4, 4'd0, 4'd0, 4'b0011, 4'b1000);
    rec2 = mk(4'd2, 4'd0, 4'd6, 4'd0, 4'b0101, 4'b0010);
    rec3 = mk(4'd3, 4'd5, 4'd7, 4'd8, 4'b0000, 4'b1111);
    pat  = 4'b1001;

    clear         = 1'b1;
    bif.in_data   = 8'h00;
    bif.in_valid  = 1'b0;
    bif.in_last   = 1'b0;
    cif.out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    check("rst_col_valid", {31'd0, cif.col_valid}, 32'd0);
    check("rst_frame_start", {31'd0, cif.frame_start}, 32'd0);
    check("rst_flags", {30'd0, bad_char, overflow}, 32'd0);
    check("rst_rec", {8'd0, obs_rec()}, 32'd0);
    clear = 1'b0;
    @(negedge clock);

    // basic frame, with frame_start pulse and first-record latency
    send_byte("1", 1'b0);
    check("fs_pulse", {31'd0, cif.frame_start}, 32'd1);
    send_byte("2", 1'b0);
    check("fs_once", {31'd0, cif.frame_start}, 32'd0);
    send_byte(" ", 1'b0);
    send_byte("3", 1'b0);
    send_byte(8'h0A, 1'b0);
    send_row("4  5", 1'b0);
    send_row(" 6 7", 1'b0);
    send_row("   8", 1'b0);
    send_row("*  +", 1'b0);
    check("scan_entry_valid", {31'd0, cif.col_valid}, 32'd0);
    check("scan_in_ready", {31'd0, bif.in_ready}, 32'd0);
    @(negedge clock);
    check("first_latency", {31'd0, cif.col_valid}, 32'd1);
    expect_rec("basic1", rec1);
    expect_rec("basic2", rec2);
    expect_rec("basic3", rec3);
    check("basic_idle_ready", {31'd0, bif.in_ready}, 32'd1);
    check("basic_idle_valid", {31'd0, cif.col_valid}, 32'd0);
    check("basic_bad", {31'd0, bad_char}, 32'd0);

    // backpressure: out_ready 1,0,0,1 repeating
    send_basic();
    ncap = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev = '0;
    while (ncap < 3 && cyc < 60) begin
      cur = obs_rec();
      if (prev_stall && cif.col_valid) check("bp_hold", {8'd0, cur}, {8'd0, prev});
      cif.out_ready = pat[cyc % 4];
      if (cif.col_valid && cif.out_ready) begin
        cap[ncap] = cur;
        ncap++;
      end
      prev_stall = cif.col_valid && !cif.out_ready;
      prev = cur;
      cyc++;
      @(negedge clock);
    end
    cif.out_ready = 1'b1;
    check("bp_count", ncap, 32'd3);
    check("bp_rec1", {8'd0, cap[0]}, {8'd0, rec1});
    check("bp_rec2", {8'd0, cap[1]}, {8'd0, rec2});
    check("bp_rec3", {8'd0, cap[2]}, {8'd0, rec3});
    @(negedge clock);
    check("bp_no_dup", {31'd0, cif.col_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, bif.in_ready}, 32'd1);

    // short rows, in_last on the op byte
    send_row("9", 1'b0);
    send_row("", 1'b0);
    send_row("", 1'b0);
    send_row("", 1'b0);
    send_byte("+", 1'b1);
    expect_rec("short", mk(4'd9, 4'd0, 4'd0, 4'd0, 4'b0111, 4'b1111));
    check("short_bad", {31'd0, bad_char}, 32'd0);

    // illegal character in row 1
    send_row("1", 1'b0);
    send_byte("x", 1'b0);
    check("bad_set", {31'd0, bad_char}, 32'd1);
    send_byte(8'h0A, 1'b0);
    send_row("", 1'b0);
    send_row("", 1'b0);
    send_row("*", 1'b0);
    expect_rec("bad_rec", mk(4'd1, 4'd0, 4'd0, 4'd0, 4'b0111, 4'b1011));
    check("bad_sticky", {31'd0, bad_char}, 32'd1);

    // overflow: 5000-char row 0
    send_byte("7", 1'b0);
    check("bad_cleared", {31'd0, bad_char}, 32'd0);
    for (int i = 1; i < 4096; i++) send_byte(" ", 1'b0);
    check("ovf_at_limit", {31'd0, overflow}, 32'd0);
    send_byte(" ", 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 4097; i < 5000; i++) send_byte(" ", 1'b0);
    send_byte(8'h0A, 1'b0);
    send_row("", 1'b0);
    send_row("", 1'b0);
    send_row("", 1'b0);
    send_row("*", 1'b0);
    expect_rec("ovf_rec", mk(4'd7, 4'd0, 4'd0, 4'd0, 4'b0111, 4'b1011));
    check("ovf_sticky", {30'd0, bad_char, overflow}, 32'd1);

    // clear in mid-scan, then reload
    send_basic();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    expect_rec("rst_rec1", rec1);
    check("rst_pre_valid", {31'd0, cif.col_valid}, 32'd1);
    #1 clear = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, cif.col_valid}, 32'd0);
    check("rst_async_ready", {31'd0, bif.in_ready}, 32'd1);
    check("rst_async_rec", {8'd0, obs_rec()}, 32'd0);
    #1 clear = 1'b0;
    @(negedge clock);
    check("rst_no_partial", {31'd0, cif.col_valid}, 32'd0);
    send_basic();
    expect_rec("reload1", rec1);
    expect_rec("reload2", rec2);
    expect_rec("reload3", rec3);

    // back-to-back shorter frame; stale row 0 data beyond its length is hidden
    check("b2b_ready", {31'd0, bif.in_ready}, 32'd1);
    send_row("5", 1'b0);
    send_row("16", 1'b0);
    send_row("", 1'b0);
    send_row("", 1'b0);
    send_row("+*", 1'b0);
    expect_rec("b2b1", mk(4'd5, 4'd1, 4'd0, 4'd0, 4'b0011, 4'b1100));
    expect_rec("b2b2", mk(4'd0, 4'd6, 4'd0, 4'd0, 4'b1011, 4'b0011));
    for (int i = 0; i < 4; i++) begin
      check("b2b_no_extra", {31'd0, cif.col_valid}, 32'd0);
      @(negedge clock);
    end
    check("b2b_end_ready", {31'd0, bif.in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/day6_col_feeder.md
# day6_col_feeder

Upstream stage of the Day 6 worksheet pipeline. Accepts the raw puzzle text as a byte stream (four digit rows plus one operator row, row-major, newline-terminated), buffers it in on-chip line buffers, then replays it column-major as per-column records. Each record carries four digits with space flags, plus block framing (`block_start`, `block_plus`, `col_last`, `frame_last`), through a valid/ready handshake directly into the column solver's inputs. Separator columns are dropped.

## Interface
- `MAX_COLS`, 4096: line-buffer depth per row, in characters.
- `CW`, clog2(MAX_COLS)+1: width of column counters.

- `clock`  in  1  sole clock; all state changes on the rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  ASCII byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  final byte of the frame; qualified by `in_valid`.
- `in_ready`  out  1  block accepts a byte this cycle.
- `frame_start`  out  1  one-cycle pulse when the first byte of a frame is accepted. Drives the consumer's `load`.
- `r0_digit`..`r3_digit`  out  4 each  digit value for rows 0-3 of the current column.
- `r0_space`..`r3_space`  out  1 each  row has no digit in this column.
- `block_start`  out  1  first column of a problem block.
- `block_plus`  out  1  block operator is '+'. Meaningful only with `block_start`; 0 otherwise.
- `col_last`  out  1  last column of the block.
- `frame_last`  out  1  last column of the frame.
- `col_valid`  out  1  column record valid.
- `out_ready`  in  1  consumer accepts the record.
- `bad_char`  out  1  sticky: an illegal character was seen this frame.
- `overflow`  out  1  sticky: a row exceeded `MAX_COLS`.

## Operation
- FSM states: IDLE, LOAD, SCAN, DONE. `in_ready` = (state is IDLE or LOAD).
- **IDLE**
  - On the first accepted byte: pulse `frame_start`, clear `bad_char`, `overflow`, row index, all row lengths, `last_occ` and its flag.
  - Treat the byte as in LOAD and go to LOAD.
- **LOAD: storing characters**
  - Byte is written at [row][col], then `col` increments.
  - Rows 0-3: '0'-'9' store digit = byte-0x30, space=0. ' ' stores digit 0, space 1.
  - Row 4: stores a 2-bit op code: '+', '*' or ' '.
  - Any other byte is stored as space and sets `bad_char`.
  - `col` ≥ `MAX_COLS`: byte is dropped and `overflow` is set.
- **LOAD: occupancy and row ends**
  - Any non-space store updates `last_occ` = max(`last_occ`, col) and sets `occ_seen`.
  - 0x0A: `len[row]` ← col, row++, col ← 0. Not stored.
  - Newline ending row 4, or `in_last`, closes the frame. `in_last` on a non-newline byte stores that byte, then closes the current row.
  - On close: rows not yet received get len 0; go to SCAN with ptr 0. If `occ_seen`=0, go to IDLE instead and emit nothing.
- **Column read**
  - A character at col ≥ `len[row]` reads as space. Buffers are never cleared between frames.
  - Separator column: all four rows space and op blank.
- **SCAN**
  - The pointer advances when the output register is empty or being accepted.
  - Separator column: skip and set `after_sep`. Otherwise load the record.
  - `block_start` = (ptr==0) | `after_sep`, and `after_sep` is then cleared.
  - `block_plus` = `block_start` & op=='+'.
  - A block start whose op is not '+'/'*' sets `bad_char` and uses multiply.
  - `col_last` = (ptr==`last_occ`) | column ptr+1 is a separator.
  - `frame_last` = (ptr==`last_occ`).
  - After loading the `last_occ` column, go to DONE.
- **DONE**: when the final record is accepted, go to IDLE.
- **Reset**
  - All outputs 0 except `in_ready`=1. State IDLE; all counters 0.
  - `clear` asserted mid-frame aborts it. No partial record survives.

## Timing
- Input: one byte per cycle when `in_valid` & `in_ready`.
- First record is valid 2 cycles after the closing byte is accepted: SCAN entry, then register load.
- Output record is registered. It stays stable while `col_valid` & !`out_ready`.
- Sustained throughput is 1 record per cycle with `out_ready` held high. Each separator column costs one bubble cycle.
- `frame_start` is asserted for exactly one cycle, in the cycle after the first byte is accepted.
- `in_ready` is low from the close cycle+1 until DONE exits.
- `bad_char` and `overflow` are valid from the cycle after the offending byte until the next `frame_start`.

## Test plan
- **Basic frame**: rows "12 3", "4  5", " 6 7", "   8", op "*  +", each newline-terminated. Expect 3 records:
  - 1: digits (1,4,-,-), `block_start`=1, `block_plus`=0.
  - 2: digits (2,-,6,-), `col_last`=1.
  - 3: digits (3,5,7,8), `block_start`=1, `block_plus`=1, `col_last`=1, `frame_last`=1.
- **Backpressure**: same frame, `out_ready` toggling 1,0,0,1 per cycle. Records must be identical, with no loss or duplication, and held stable while stalled.
- **Short rows, no trailing newline**: rows "9", "", "", "", op "+" with `in_last` on '+'. Expect one record: digits (9,-,-,-) with `block_start`, `block_plus`, `col_last`, `frame_last` all 1.
- **Errors**: an 'x' in row 1 sets `bad_char` and reads as space. A 5000-char row with `MAX_COLS`=4096 sets `overflow`. Both flags clear on the next `frame_start`.
- **Reset mid-scan**: assert `clear` after 1 of 3 records. Outputs go 0 and `in_ready`=1 asynchronously. Reloading the basic frame reproduces all 3 records.
- **Back-to-back frames**: the second frame, shorter, loaded after DONE shows no stale data from the first frame beyond the new row lengths.
